// File: rtl/block_mem_pkg.sv
// ---------------------------------------------------------------------------
// block_mem_pkg : shared types, packet macros and store lane helpers for the
//                 block_mem packet interface.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef BLOCK_MEM_PKG_MACROS
`define BLOCK_MEM_PKG_MACROS
`define BLOCK_MEM_PKT_WIDTH(addr_w, data_w) \
  ($bits(block_mem_op_e) + (addr_w) + (data_w) + ((data_w) >> 3))
`define DECLARE_BLOCK_MEM_PKT_S(addr_w, data_w) \
  typedef struct packed { \
    block_mem_op_e                opcode; \
    logic [(addr_w)-1:0]          addr; \
    logic [(data_w)-1:0]          data; \
    logic [((data_w) >> 3)-1:0]   mask; \
  } block_mem_pkt_s
`endif

package block_mem_pkg;

  typedef enum logic [2:0] {
    e_nop   = 3'd0,
    e_lw    = 3'd1,
    e_lh    = 3'd2,
    e_lhu   = 3'd3,
    e_lb    = 3'd4,
    e_lbu   = 3'd5,
    e_store = 3'd6
  } block_mem_op_e;

  typedef enum logic [1:0] {
    e_size_byte = 2'd0,
    e_size_half = 2'd1,
    e_size_word = 2'd2
  } block_mem_size_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } block_mem_lanes_s;

  // Store data is right-justified on input; replicate it across lanes so the
  // byte mask alone selects what the memory writes.
  function automatic block_mem_lanes_s block_mem_store_lanes(
    block_mem_size_e size, logic [1:0] addr_lo, logic [31:0] data);
    block_mem_lanes_s l;
    case (size)
      e_size_byte: begin
        l.data = {4{data[7:0]}};
        l.mask = 4'b0001 << addr_lo;
      end
      e_size_half: begin
        l.data = {2{data[15:0]}};
        l.mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        l.data = data;
        l.mask = 4'b1111;
      end
    endcase
    return l;
  endfunction

  function automatic logic block_mem_misaligned(
    block_mem_op_e op, block_mem_size_e size, logic [1:0] addr_lo);
    logic is_half;
    logic is_word;
    is_half = (op == e_lh) | (op == e_lhu) | ((op == e_store) & (size == e_size_half));
    is_word = (op == e_lw)
            | ((op == e_store) & (size != e_size_byte) & (size != e_size_half));
    return (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_two_fifo.sv
// ---------------------------------------------------------------------------
// bsg_two_fifo : two-entry valid/ready in, valid/yumi out FIFO.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_two_fifo #(
  parameter width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      wptr_r  <= wptr_r ^ enq;
      rptr_r  <= rptr_r ^ deq;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/bsg_manycore_block_mem_req.sv
// ---------------------------------------------------------------------------
// bsg_manycore_block_mem_req : credit-based requester for block_mem packets.
//   Define BSG_BLOCK_MEM_REQ_ALIGN_CHECK_EN to flag misaligned requests.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_manycore_block_mem_req
  import block_mem_pkg::*;
#(
  parameter mem_addr_width_p = 12,
  parameter data_width_p     = 32,
  parameter tag_width_p      = 4,
  parameter pkt_width_lp     = `BLOCK_MEM_PKT_WIDTH(mem_addr_width_p, data_width_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [$bits(block_mem_op_e)-1:0] op_i,
  input  logic [1:0]                  size_i,
  input  logic [mem_addr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0]     data_i,
  input  logic [tag_width_p-1:0]      tag_i,
  output logic                        mem_v_o,
  output logic [pkt_width_lp-1:0]     mem_pkt_o,
  input  logic [data_width_p-1:0]     mem_data_i,
  output logic                        v_o,
  output logic [data_width_p-1:0]     data_o,
  output logic [tag_width_p-1:0]      tag_o,
  output logic                        err_o,
  input  logic                        yumi_i
);

  `DECLARE_BLOCK_MEM_PKT_S(mem_addr_width_p, data_width_p);

  localparam entry_width_lp = data_width_p + tag_width_p + 1;

  block_mem_op_e    op;
  block_mem_lanes_s lanes;
  block_mem_pkt_s   pkt;
  logic [1:0]       credits_r;
  logic             fire;
  logic             misaligned;

  assign op      = block_mem_op_e'(op_i);
  assign ready_o = (credits_r != 2'd0);
  assign fire    = v_i & ready_o & (op != e_nop);

`ifdef BSG_BLOCK_MEM_REQ_ALIGN_CHECK_EN
  assign misaligned = block_mem_misaligned(op, block_mem_size_e'(size_i), addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign mem_v_o = fire & ~misaligned;
  assign lanes   = block_mem_store_lanes(block_mem_size_e'(size_i), addr_i[1:0], data_i);

  always_comb begin
    pkt.opcode = op;
    pkt.addr   = addr_i;
    pkt.data   = (op == e_store) ? lanes.data : '0;
    pkt.mask   = (op == e_store) ? lanes.mask : '0;
  end
  assign mem_pkt_o = pkt;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      credits_r <= 2'd2;
    else if (fire & ~yumi_i)
      credits_r <= credits_r - 2'd1;
    else if (yumi_i & ~fire)
      credits_r <= credits_r + 2'd1;
  end

  logic                   v_r;
  logic [tag_width_p-1:0] tag_r;
  logic                   err_r;
  logic                   zero_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      tag_r  <= '0;
      err_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      v_r <= fire;
      if (fire) begin
        tag_r  <= tag_i;
        err_r  <= misaligned;
        zero_r <= misaligned | (op == e_store);
      end
    end
  end

  logic [entry_width_lp-1:0] inflight_entry;
  logic [entry_width_lp-1:0] fifo_data;
  logic [entry_width_lp-1:0] head;
  logic                      fifo_v;
  logic                      fifo_ready;
  logic                      bypass;
  logic                      enq;

  assign inflight_entry = {(zero_r ? '0 : mem_data_i), tag_r, err_r};

  // With the buffer empty the returning response is presented directly, so a
  // credit comes back one cycle sooner and a yumi every cycle sustains issue.
  assign bypass = ~fifo_v & v_r;
  assign enq    = v_r & fifo_ready & ~(bypass & yumi_i);

  bsg_two_fifo #(
    .width_p (entry_width_lp)
  ) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (fifo_ready),
    .data_i  (inflight_entry),
    .v_i     (enq),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (yumi_i & fifo_v)
  );

  assign v_o  = fifo_v | v_r;
  assign head = fifo_v ? fifo_data : inflight_entry;
  assign {data_o, tag_o, err_o} = head;

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_block_mem_req.sv
// ---------------------------------------------------------------------------
// tb_bsg_manycore_block_mem_req : requester driving a 1-cycle block memory model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bsg_manycore_block_mem_req;
  import block_mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int PW = `BLOCK_MEM_PKT_WIDTH(AW, DW);

  `DECLARE_BLOCK_MEM_PKT_S(AW, DW);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
  } resp_s;

  logic          clk;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [2:0]    op_i;
  logic [1:0]    size_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i;
  logic [TW-1:0] tag_i;
  logic          mem_v_o;
  logic [PW-1:0] mem_pkt_o;
  logic [DW-1:0] mem_data_i;
  logic          v_o;
  logic [DW-1:0] data_o;
  logic [TW-1:0] tag_o;
  logic          err_o;
  logic          yumi_i;

  int total = 0;
  int bad   = 0;

  bsg_manycore_block_mem_req #(
    .mem_addr_width_p (AW),
    .data_width_p     (DW),
    .tag_width_p      (TW)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .size_i     (size_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .tag_i      (tag_i),
    .mem_v_o    (mem_v_o),
    .mem_pkt_o  (mem_pkt_o),
    .mem_data_i (mem_data_i),
    .v_o        (v_o),
    .data_o     (data_o),
    .tag_o      (tag_o),
    .err_o      (err_o),
    .yumi_i     (yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory model: word i initialised to C0DE0000|i, 1-cycle read latency.
  logic [31:0]    mem [64];
  block_mem_pkt_s mp;
  assign mp = mem_pkt_o;

  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    if (reset_i) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hC0DE0000 | 32'(k);
    end else if (mem_v_o) begin
      w = mem[mp.addr[7:2]];
      h = mp.addr[1] ? w[31:16] : w[15:0];
      b = w[{mp.addr[1:0], 3'b000} +: 8];
      case (mp.opcode)
        e_store: for (int k = 0; k < 4; k++)
                   if (mp.mask[k]) mem[mp.addr[7:2]][8*k +: 8] <= mp.data[8*k +: 8];
        e_lw:    mem_data_i <= w;
        e_lh:    mem_data_i <= {{16{h[15]}}, h};
        e_lhu:   mem_data_i <= {16'h0, h};
        e_lb:    mem_data_i <= {{24{b[7]}}, b};
        e_lbu:   mem_data_i <= {24'h0, b};
        default: mem_data_i <= 32'h0;
      endcase
    end
  end

  int             cyc = 0;
  block_mem_pkt_s pkt_q[$];
  int             pkt_cyc_q[$];
  resp_s          resp_q[$];
  bit             auto_yumi   = 1'b0;
  bit             manual_yumi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_v_o) begin
      pkt_q.push_back(mp);
      pkt_cyc_q.push_back(cyc);
    end
    if (v_o && yumi_i) resp_q.push_back({data_o, tag_o, err_o});
  end

  always @(posedge clk) begin
    #2;
    yumi_i = v_o & (auto_yumi | manual_yumi);
  end

  task automatic clear_logs();
    pkt_q.delete();
    pkt_cyc_q.delete();
    resp_q.delete();
  endtask

  task automatic drive(block_mem_op_e op, block_mem_size_e sz, logic [7:0] addr,
                       logic [31:0] data, logic [3:0] tag);
    v_i = 1'b1; op_i = op; size_i = sz; addr_i = addr; data_i = data; tag_i = tag;
  endtask

  task automatic idle();
    v_i = 1'b0; op_i = e_nop; size_i = e_size_word; addr_i = '0; data_i = '0; tag_i = '0;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout: ready_o stayed %b, required 1", ready_o);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(block_mem_op_e op, block_mem_size_e sz, logic [7:0] addr,
                      logic [31:0] data, logic [3:0] tag);
    drive(op, sz, addr, data, tag);
    wait_accept();
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    total++; if (v_o !== 1'b0)     begin bad++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    total++; if (mem_v_o !== 1'b0) begin bad++; $display("FAIL reset_mem_v: got %b want 0", mem_v_o); end
    total++; if (err_o !== 1'b0)   begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    @(posedge clk); #1;
    reset_i = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_nop();
    clear_logs();
    auto_yumi = 1'b1;
    drive(e_nop, e_size_word, 8'h40, 32'h1234, 4'hF);
    #1;
    total++; if (mem_v_o !== 1'b0) begin bad++; $display("FAIL nop_mem_v: got %b want 0", mem_v_o); end
    wait_accept();
    idle();
    wait_cycles(3);
    total++; if (pkt_q.size() != 0 || resp_q.size() != 0) begin
      bad++; $display("FAIL nop_traffic: pkts=%0d resps=%0d want 0 0", pkt_q.size(), resp_q.size());
    end
  endtask

  task automatic test_store_load();
    resp_s e;
    clear_logs();
    auto_yumi = 1'b1;
    send(e_store, e_size_word, 8'h10, 32'hDEADBEEF, 4'd1);
    send(e_lw,    e_size_word, 8'h10, 32'h0,       4'd2);
    idle();
    wait_cycles(4);
    total++; if (pkt_q.size() != 2) begin bad++; $display("FAIL sl_pkt_count: got %0d want 2", pkt_q.size()); end
    else begin
      total++; if (pkt_q[0].mask !== 4'hF || pkt_q[0].data !== 32'hDEADBEEF || pkt_q[0].addr !== 8'h10) begin
        bad++; $display("FAIL sw_pkt: got mask %b data %h addr %h want 1111 deadbeef 10",
                        pkt_q[0].mask, pkt_q[0].data, pkt_q[0].addr);
      end
      total++; if (pkt_q[1].mask !== 4'h0 || pkt_q[1].data !== 32'h0 || pkt_q[1].opcode !== e_lw) begin
        bad++; $display("FAIL lw_pkt: got mask %b data %h want 0000 0", pkt_q[1].mask, pkt_q[1].data);
      end
    end
    total++; if (resp_q.size() != 2) begin bad++; $display("FAIL sl_resp_count: got %0d want 2", resp_q.size()); end
    else begin
      e = '{data: 32'h0, tag: 4'd1, err: 1'b0};
      total++; if (resp_q[0] !== e) begin bad++; $display("FAIL sw_ack: got %h want %h", resp_q[0], e); end
      e = '{data: 32'hDEADBEEF, tag: 4'd2, err: 1'b0};
      total++; if (resp_q[1] !== e) begin bad++; $display("FAIL lw_data: got %h want %h", resp_q[1], e); end
    end
  endtask

  task automatic test_byte_half();
    resp_s e;
    clear_logs();
    auto_yumi = 1'b1;
    send(e_store, e_size_byte, 8'h13, 32'h00000080, 4'd3);
    send(e_lb,    e_size_byte, 8'h13, 32'h0,        4'd4);
    send(e_lbu,   e_size_byte, 8'h13, 32'h0,        4'd5);
    send(e_store, e_size_half, 8'h16, 32'h1234ABCD, 4'd6);
    send(e_lhu,   e_size_half, 8'h16, 32'h0,        4'd7);
    idle();
    wait_cycles(4);
    total++; if (pkt_q.size() != 5) begin bad++; $display("FAIL bh_pkt_count: got %0d want 5", pkt_q.size()); end
    else begin
      total++; if (pkt_q[0].data !== 32'h80808080 || pkt_q[0].mask !== 4'b1000) begin
        bad++; $display("FAIL sb_pkt: got data %h mask %b want 80808080 1000", pkt_q[0].data, pkt_q[0].mask);
      end
      total++; if (pkt_q[3].data !== 32'hABCDABCD || pkt_q[3].mask !== 4'b1100) begin
        bad++; $display("FAIL sh_pkt: got data %h mask %b want abcdabcd 1100", pkt_q[3].data, pkt_q[3].mask);
      end
    end
    total++; if (resp_q.size() != 5) begin bad++; $display("FAIL bh_resp_count: got %0d want 5", resp_q.size()); end
    else begin
      e = '{data: 32'hFFFFFF80, tag: 4'd4, err: 1'b0};
      total++; if (resp_q[1] !== e) begin bad++; $display("FAIL lb_data: got %h want %h", resp_q[1], e); end
      e = '{data: 32'h00000080, tag: 4'd5, err: 1'b0};
      total++; if (resp_q[2] !== e) begin bad++; $display("FAIL lbu_data: got %h want %h", resp_q[2], e); end
      e = '{data: 32'h0000ABCD, tag: 4'd7, err: 1'b0};
      total++; if (resp_q[4] !== e) begin bad++; $display("FAIL lhu_data: got %h want %h", resp_q[4], e); end
    end
  endtask

  task automatic test_backpressure();
    resp_s e;
    clear_logs();
    auto_yumi = 1'b0;
    manual_yumi = 1'b0;
    send(e_lw, e_size_word, 8'h20, 32'h0, 4'd6);
    send(e_lw, e_size_word, 8'h24, 32'h0, 4'd7);
    drive(e_lw, e_size_word, 8'h28, 32'h0, 4'd8);
    repeat (3) @(negedge clk);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", ready_o); end
    total++; if (pkt_q.size() != 2) begin bad++; $display("FAIL bp_issued: got %0d want 2", pkt_q.size()); end
    manual_yumi = 1'b1;
    wait_accept();
    send(e_lw, e_size_word, 8'h2C, 32'h0, 4'd9);
    idle();
    wait_cycles(6);
    manual_yumi = 1'b0;
    total++; if (pkt_q.size() != 4) begin bad++; $display("FAIL bp_total_issued: got %0d want 4", pkt_q.size()); end
    total++; if (resp_q.size() != 4) begin bad++; $display("FAIL bp_resp_count: got %0d want 4", resp_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        e = '{data: 32'hC0DE0008 + 32'(i), tag: 4'(6 + i), err: 1'b0};
        total++; if (resp_q[i] !== e) begin bad++; $display("FAIL bp_resp%0d: got %h want %h", i, resp_q[i], e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    resp_s e;
    clear_logs();
    auto_yumi = 1'b1;
    for (int i = 0; i < 16; i++) send(e_lw, e_size_word, 8'(8'h40 + 4 * i), 32'h0, 4'(i));
    idle();
    wait_cycles(5);
    total++; if (pkt_q.size() != 16) begin bad++; $display("FAIL b2b_count: got %0d want 16", pkt_q.size()); end
    else begin
      total++; if (pkt_cyc_q[15] - pkt_cyc_q[0] != 15) begin
        bad++; $display("FAIL b2b_span: got %0d cycles want 15", pkt_cyc_q[15] - pkt_cyc_q[0]);
      end
    end
    total++; if (resp_q.size() != 16) begin bad++; $display("FAIL b2b_resp_count: got %0d want 16", resp_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        e = '{data: 32'hC0DE0010 + 32'(i), tag: 4'(i), err: 1'b0};
        total++; if (resp_q[i] !== e) begin bad++; $display("FAIL b2b_resp%0d: got %h want %h", i, resp_q[i], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    auto_yumi = 1'b0;
    manual_yumi = 1'b0;
    send(e_lw, e_size_word, 8'h30, 32'h0, 4'hA);
    send(e_lw, e_size_word, 8'h34, 32'h0, 4'hB);
    idle();
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    total++; if (v_o !== 1'b0)     begin bad++; $display("FAIL rst_mid_v_o: got %b want 0", v_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", ready_o); end
    manual_yumi = 1'b1;
    wait_cycles(4);
    manual_yumi = 1'b0;
    total++; if (resp_q.size() != 0) begin bad++; $display("FAIL rst_mid_stale: got %0d responses want 0", resp_q.size()); end
  endtask

  task automatic test_align();
    resp_s e;
    clear_logs();
    auto_yumi = 1'b1;
    send(e_lh, e_size_half, 8'h21, 32'h0, 4'hC);
    idle();
    wait_cycles(4);
`ifdef BSG_BLOCK_MEM_REQ_ALIGN_CHECK_EN
    total++; if (pkt_q.size() != 0) begin bad++; $display("FAIL align_pkt: got %0d pkts want 0", pkt_q.size()); end
    e = '{data: 32'h0, tag: 4'hC, err: 1'b1};
`else
    total++; if (pkt_q.size() != 1) begin bad++; $display("FAIL align_pkt: got %0d pkts want 1", pkt_q.size()); end
    else begin
      total++; if (pkt_q[0].addr !== 8'h21) begin bad++; $display("FAIL align_addr: got %h want 21", pkt_q[0].addr); end
    end
    e = '{data: 32'h00000008, tag: 4'hC, err: 1'b0};
`endif
    total++; if (resp_q.size() != 1) begin bad++; $display("FAIL align_resp_count: got %0d want 1", resp_q.size()); end
    else begin
      total++; if (resp_q[0] !== e) begin bad++; $display("FAIL align_resp: got %h want %h", resp_q[0], e); end
    end
  endtask

  initial begin
    yumi_i  = 1'b0;
    reset_i = 1'b1;
    idle();
    test_reset();
    test_nop();
    test_store_load();
    test_byte_half();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
